// File: rtl/bit_debounce_edge_if.sv
// Signal bundle between a level source and the bit_debounce_edge qualifier.
// glitch_cnt exists only when BIT_DEBOUNCE_GLITCH_CNT_EN is defined.
interface bit_debounce_edge_if #(
    parameter int CNT_W = 8
);
    logic             ena;
    logic             d;
    logic             q_stable;
    logic             rise;
    logic             fall;
    logic [CNT_W-1:0] edge_cnt;
`ifdef BIT_DEBOUNCE_GLITCH_CNT_EN
    logic [CNT_W-1:0] glitch_cnt;

    modport master (output ena, d, input q_stable, rise, fall, edge_cnt, glitch_cnt);
    modport slave  (input ena, d, output q_stable, rise, fall, edge_cnt, glitch_cnt);
`else
    modport master (output ena, d, input q_stable, rise, fall, edge_cnt);
    modport slave  (input ena, d, output q_stable, rise, fall, edge_cnt);
`endif
endinterface

// File: rtl/bit_debounce_edge.sv
// Single-bit debouncer: accepts a level after STABLE_CYCLES stable samples, pulses rise/fall,
// counts qualified edges. Define BIT_DEBOUNCE_GLITCH_CNT_EN to add a saturating glitch counter.
module bit_debounce_edge #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic                clk,
    input  logic                reset,
    bit_debounce_edge_if.slave  bus
);

    if (STABLE_CYCLES < 2 || STABLE_CYCLES > (2**CNT_W) - 1) begin : g_bad_param
        $error("bit_debounce_edge: STABLE_CYCLES out of range 2..2**CNT_W-1");
    end

    localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE_LOW   = 2'd0,
        CHECK_HIGH = 2'd1,
        IDLE_HIGH  = 2'd2,
        CHECK_LOW  = 2'd3
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             d_r;
    logic             q_stable, q_stable_n;
    logic             rise, rise_n;
    logic             fall, fall_n;
    logic [CNT_W-1:0] edge_cnt, edge_cnt_n;

`ifdef BIT_DEBOUNCE_GLITCH_CNT_EN
    logic [CNT_W-1:0] glitch_cnt, glitch_cnt_n;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction
`endif

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        q_stable_n = q_stable;
        rise_n     = 1'b0;
        fall_n     = 1'b0;
        edge_cnt_n = edge_cnt;
`ifdef BIT_DEBOUNCE_GLITCH_CNT_EN
        glitch_cnt_n = glitch_cnt;
`endif
        if (bus.ena) begin
            unique case (state)
                IDLE_LOW: begin
                    if (d_r) begin
                        state_n = CHECK_HIGH;
                        cnt_n   = CNT_W'(1);
                    end
                end
                CHECK_HIGH: begin
                    if (!d_r) begin
                        state_n = IDLE_LOW;
`ifdef BIT_DEBOUNCE_GLITCH_CNT_EN
                        glitch_cnt_n = sat_inc(glitch_cnt);
`endif
                    end else if (cnt == LAST) begin
                        state_n    = IDLE_HIGH;
                        q_stable_n = 1'b1;
                        rise_n     = 1'b1;
                        edge_cnt_n = edge_cnt + 1'b1;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                IDLE_HIGH: begin
                    if (!d_r) begin
                        state_n = CHECK_LOW;
                        cnt_n   = CNT_W'(1);
                    end
                end
                CHECK_LOW: begin
                    if (d_r) begin
                        state_n = IDLE_HIGH;
`ifdef BIT_DEBOUNCE_GLITCH_CNT_EN
                        glitch_cnt_n = sat_inc(glitch_cnt);
`endif
                    end else if (cnt == LAST) begin
                        state_n    = IDLE_LOW;
                        q_stable_n = 1'b0;
                        fall_n     = 1'b1;
                        edge_cnt_n = edge_cnt + 1'b1;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                default: state_n = IDLE_LOW;
            endcase
        end
    end

    // Input sample stage runs regardless of ena; the FSM only ever looks at d_r.
    always_ff @(posedge clk) begin
        if (reset) begin
            d_r      <= 1'b0;
            state    <= IDLE_LOW;
            cnt      <= '0;
            q_stable <= 1'b0;
            rise     <= 1'b0;
            fall     <= 1'b0;
            edge_cnt <= '0;
`ifdef BIT_DEBOUNCE_GLITCH_CNT_EN
            glitch_cnt <= '0;
`endif
        end else begin
            d_r      <= bus.d;
            state    <= state_n;
            cnt      <= cnt_n;
            q_stable <= q_stable_n;
            rise     <= rise_n;
            fall     <= fall_n;
            edge_cnt <= edge_cnt_n;
`ifdef BIT_DEBOUNCE_GLITCH_CNT_EN
            glitch_cnt <= glitch_cnt_n;
`endif
        end
    end

    assign bus.q_stable = q_stable;
    assign bus.rise     = rise;
    assign bus.fall     = fall;
    assign bus.edge_cnt = edge_cnt;
`ifdef BIT_DEBOUNCE_GLITCH_CNT_EN
    assign bus.glitch_cnt = glitch_cnt;
`endif

endmodule

// File: tb/tb_bit_debounce_edge.sv
// Directed bench for bit_debounce_edge (STABLE_CYCLES=4, CNT_W=8); glitch_cnt checks
// are active when BIT_DEBOUNCE_GLITCH_CNT_EN is defined.
`timescale 1ns/1ps
module tb_bit_debounce_edge;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    logic [7:0] exp_edge = 8'd0;

    bit_debounce_edge_if #(.CNT_W(8)) bus ();

    bit_debounce_edge #(.STABLE_CYCLES(4), .CNT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout act=running exp=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0d exp=%0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive d to v and expect qualification exactly on the 5th edge (1 sample-stage + 4 checks).
    task automatic qualify(input logic v);
        bus.d = v;
        repeat (4) tick();
        chk("pre_q", bus.q_stable, !v);
        chk("pre_pulse", {bus.rise, bus.fall}, 2'b00);
        tick();
        exp_edge = exp_edge + 8'd1;
        chk("q", bus.q_stable, v);
        chk("rise", bus.rise, v);
        chk("fall", bus.fall, !v);
        chk("edge_cnt", bus.edge_cnt, exp_edge);
        tick();
        chk("post_pulse", {bus.rise, bus.fall}, 2'b00);
    endtask

    initial begin
        reset   = 1'b1;
        bus.ena = 1'b1;
        bus.d   = 1'b1;
        tick();
        tick();
        chk("rst_q", bus.q_stable, 0);
        chk("rst_pulse", {bus.rise, bus.fall}, 2'b00);
        chk("rst_edge", bus.edge_cnt, 0);
`ifdef BIT_DEBOUNCE_GLITCH_CNT_EN
        chk("rst_glitch", bus.glitch_cnt, 0);
`endif
        reset = 1'b0;
        bus.d = 1'b0;
        tick();
        tick();
        chk("idle_q", bus.q_stable, 0);

        // clean rise then clean fall
        qualify(1'b1);
        repeat (4) tick();
        chk("hold_high", bus.q_stable, 1);
        qualify(1'b0);
        chk("edge_after_pair", bus.edge_cnt, 2);

        // glitch: three high samples, one short of qualifying
        bus.d = 1'b1;
        repeat (3) tick();
        bus.d = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("glitch_rise", bus.rise, 0);
            chk("glitch_q", bus.q_stable, 0);
        end
        chk("glitch_edge", bus.edge_cnt, 2);
`ifdef BIT_DEBOUNCE_GLITCH_CNT_EN
        chk("glitch_cnt1", bus.glitch_cnt, 1);
`endif

        // enable hold: cnt reaches 2, freezes for 5 cycles, resumes
        bus.d = 1'b1;
        repeat (3) tick();
        bus.ena = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("ena0_q", bus.q_stable, 0);
            chk("ena0_rise", bus.rise, 0);
        end
        bus.ena = 1'b1;
        tick();
        chk("resume1_q", bus.q_stable, 0);
        chk("resume1_rise", bus.rise, 0);
        tick();
        chk("resume2_q", bus.q_stable, 1);
        chk("resume2_rise", bus.rise, 1);
        chk("resume2_edge", bus.edge_cnt, 3);
        tick();
        chk("resume3_rise", bus.rise, 0);
        exp_edge = 8'd3;
        qualify(1'b0);

        // reset while CHECK_HIGH holds cnt=3 (next edge would qualify)
        bus.d = 1'b1;
        repeat (4) tick();
        chk("midchk_q", bus.q_stable, 0);
        reset = 1'b1;
        tick();
        chk("midrst_q", bus.q_stable, 0);
        chk("midrst_rise", bus.rise, 0);
        chk("midrst_edge", bus.edge_cnt, 0);
`ifdef BIT_DEBOUNCE_GLITCH_CNT_EN
        chk("midrst_glitch", bus.glitch_cnt, 0);
`endif
        reset = 1'b0;
        exp_edge = 8'd0;
        qualify(1'b1);

        // edge_cnt wrap: reach 255, then one more transition returns to 0
        for (int i = 0; i < 254; i++) qualify(bus.q_stable ? 1'b0 : 1'b1);
        chk("edge_255", bus.edge_cnt, 255);
        qualify(bus.q_stable ? 1'b0 : 1'b1);
        chk("edge_wrap", bus.edge_cnt, 0);

        // 300 one-sample glitches from a settled low level
        if (bus.q_stable) qualify(1'b0);
        bus.d = 1'b0;
        repeat (2) tick();
        for (int i = 0; i < 300; i++) begin
            bus.d = 1'b1;
            tick();
            bus.d = 1'b0;
            tick();
            tick();
`ifdef BIT_DEBOUNCE_GLITCH_CNT_EN
            if (i == 254) chk("glitch_255", bus.glitch_cnt, 255);
`endif
        end
        chk("glitches_q", bus.q_stable, 0);
        chk("glitches_edge", bus.edge_cnt, exp_edge);
`ifdef BIT_DEBOUNCE_GLITCH_CNT_EN
        chk("glitch_sat", bus.glitch_cnt, 255);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
